blit_addr_step: RTL
===================

Name: blit_addr_step

Overview:
- Parametrised address-step unit for the blitter address generator; next generation of the fixed two-pointer ADDB operand mux.
- Holds NPTR pointer channels, each with integer X/Y, fraction X/Y and step X/Y registers.
- Selects the B operand per command, adds it to the selected pointer, optionally writes back, and presents the result on a valid/ready output.
- Sits between the blitter sequencer (command side) and the address output / pixel-pipe stage (result side).

Parameters:
W, 16, pointer/operand width per axis
NPTR, 2, number of pointer channels (power of 2, ≥2)
PTR_W, $clog2(NPTR), pointer index width (derived)

Ports:
sys_clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_op  in  2  0=LOAD_PTR, 1=LOAD_STEP, 2=LOAD_FRAC, 3=ADD
cmd_ptr  in  PTR_W  target pointer channel
cmd_src  in  PTR_W  source channel for bsel=01
cmd_bsel  in  2  B operand: 00 own ptr, 01 ptr[cmd_src], 10 own frac, 11 own step
cmd_wb  in  1  ADD writes sum back to ptr[cmd_ptr]
cmd_x  in  W  load data X
cmd_y  in  W  load data Y
clip_w  in  W  clip window width (used only with ADDR_CLIP_EN)
clip_h  in  W  clip window height (used only with ADDR_CLIP_EN)
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_x  out  W  sum X
out_y  out  W  sum Y
out_ptr  out  PTR_W  channel the result belongs to
out_cx  out  1  carry-out of X add
out_cy  out  1  carry-out of Y add
out_clip  out  1  result outside window

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE.
  - All ptr/frac/step registers become 0.
  - out_valid, out_x, out_y, out_ptr, out_cx, out_cy, out_clip all become 0.
  - cmd_ready is 0 while reset is high.
- Reset mid-operation: the in-flight ADD is dropped, with no writeback and no out_valid.
- FSM states: IDLE, SEL, ADD, OUT.
- cmd_ready = (state==IDLE) & ~reset.
- LOAD_* accepted in IDLE:
  - Writes {cmd_x, cmd_y} into the selected register of cmd_ptr on the accepting edge.
  - State stays IDLE; no output is produced.
  - The loaded value is visible to the next command.
- ADD accepted in IDLE (cycle 0 = accept edge):
  - Command is captured; IDLE→SEL.
  - SEL (cycle 1): A = ptr[cmd_ptr] and B = operand per bsel are registered; SEL→ADD.
  - ADD (cycle 2): {cx,x} = A.x+B.x and {cy,y} = A.y+B.y, each (W+1)-bit, low W bits kept (wrap mod 2^W).
  - On the ADD exit edge: out_* are registered, out_valid=1, and if cmd_wb then ptr[cmd_ptr] is updated. ADD→OUT.
  - out_valid is first high in cycle 3.
- OUT:
  - out_* are held stable while out_valid & ~out_ready.
  - On out_valid & out_ready: out_valid=0, state→IDLE.
  - The next command can be accepted in the following cycle, so minimum ADD issue interval is 4 cycles with out_ready tied high.
- Operand values are sampled in SEL. bsel=01 with cmd_src==cmd_ptr equals bsel=00 (doubling).
- cmd_x/cmd_y are ignored for ADD; cmd_bsel/cmd_src/cmd_wb are ignored for loads.
- cmd_valid while not ready: the command is not captured and must be held by the sender.
- out_clip is 0 unless ADDR_CLIP_EN is defined.

Optional Feature:
- Macro: BLIT_ADDR_CLIP_EN.
- Defined:
  - out_clip is registered with the result: x[W-1] | y[W-1] | (x ≥ clip_w) | (y ≥ clip_h).
  - The comparisons treat x/y as signed and clip_w/clip_h as unsigned.
  - Writeback still occurs regardless of clip.
- Undefined:
  - out_clip is constant 0.
  - clip_w/clip_h are unused; no comparator logic is generated.

Decomposition:
- Package blit_addr_pkg holds:
  - op codes: OP_LOAD_PTR, OP_LOAD_STEP, OP_LOAD_FRAC, OP_ADD.
  - bsel codes: BSEL_SELF, BSEL_SRC, BSEL_FRAC, BSEL_STEP.
  - FSM state encoding.
- Sub-module blit_addb_sel: purely combinational, parametrised on W/NPTR. It selects the B operand (X and Y) from the register arrays given ptr, src and bsel.

Test Plan:
- Reset: hold reset 3 cycles mid-ADD → out_valid=0, cmd_ready=0 during reset, ready=1 the cycle after. A subsequent ADD self on ptr0 gives out_x=out_y=0.
- Load+self add: LOAD_PTR ptr1=(0x0010,0x0020), then ADD ptr1 bsel=00 wb=1 → out_valid in cycle 3, out=(0x0020,0x0040), out_ptr=1. A second identical ADD gives (0x0040,0x0080).
- Cross-pointer wrap: ptr0=(0xFFF0,0x0001), ptr1=(0x0020,0xFFFF), ADD ptr0 bsel=01 src=1 wb=0 → out=(0x0010,0x0000), cx=1, cy=1. A following self ADD shows ptr0 unchanged: (0xFFE0,0x0002), cx=1, cy=0.
- Frac/step operands: ptr0=(5,5), frac0=(1,2), step0=(0xFFFF,3). ADD bsel=10 → (6,7); ADD bsel=11 → (4,8), cx=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_* stable and cmd_ready=0 throughout. out_ready=1 → out_valid drops next cycle, cmd_ready=1.
- Clip (macro on): clip_w=320, clip_h=200; results (319,199)→clip=0, (320,10)→1, (0xFFFF,0)→1. Macro off: all give 0.

Source files
------------

// File: rtl/blit_addr_pkg.sv
// Shared definitions for the blitter address-step unit: command op codes,
// B-operand select codes and the step FSM state encoding.
package blit_addr_pkg;

    // Command op codes carried on cmd_op
    typedef enum logic [1:0] {
        OP_LOAD_PTR  = 2'd0,
        OP_LOAD_STEP = 2'd1,
        OP_LOAD_FRAC = 2'd2,
        OP_ADD       = 2'd3
    } op_e;

    // B-operand select codes carried on cmd_bsel
    typedef enum logic [1:0] {
        BSEL_SELF = 2'd0,
        BSEL_SRC  = 2'd1,
        BSEL_FRAC = 2'd2,
        BSEL_STEP = 2'd3
    } bsel_e;

    // Address-step FSM: accept, operand select, add, present result
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    // Everything except ADD is a register load that completes in IDLE
    function automatic logic is_load(input logic [1:0] op);
        return op != OP_ADD;
    endfunction

endpackage

// File: rtl/blit_addb_sel.sv
// B-operand selector for the address-step unit. Purely combinational:
// picks the X/Y operand from the pointer, fraction or step register banks
// of the addressed channel (or another pointer channel for BSEL_SRC).
module blit_addb_sel
    import blit_addr_pkg::*;
#(
    parameter int W    = 16,
    parameter int NPTR = 2,
    localparam int PTR_W = $clog2(NPTR)
) (
    input  logic [NPTR*W-1:0] ptr_x_flat,
    input  logic [NPTR*W-1:0] ptr_y_flat,
    input  logic [NPTR*W-1:0] frac_x_flat,
    input  logic [NPTR*W-1:0] frac_y_flat,
    input  logic [NPTR*W-1:0] step_x_flat,
    input  logic [NPTR*W-1:0] step_y_flat,
    input  logic [PTR_W-1:0]  sel_ptr,
    input  logic [PTR_W-1:0]  sel_src,
    input  logic [1:0]        sel_bsel,
    output logic [W-1:0]      b_x,
    output logic [W-1:0]      b_y
);

    logic [W-1:0] ptr_x  [NPTR];
    logic [W-1:0] ptr_y  [NPTR];
    logic [W-1:0] frac_x [NPTR];
    logic [W-1:0] frac_y [NPTR];
    logic [W-1:0] step_x [NPTR];
    logic [W-1:0] step_y [NPTR];

    genvar gi;
    generate
        for (gi = 0; gi < NPTR; gi++) begin : g_unpack
            assign ptr_x[gi]  = ptr_x_flat[gi*W +: W];
            assign ptr_y[gi]  = ptr_y_flat[gi*W +: W];
            assign frac_x[gi] = frac_x_flat[gi*W +: W];
            assign frac_y[gi] = frac_y_flat[gi*W +: W];
            assign step_x[gi] = step_x_flat[gi*W +: W];
            assign step_y[gi] = step_y_flat[gi*W +: W];
        end
    endgenerate

    // Operand mux; BSEL_SRC with src==ptr naturally degenerates to BSEL_SELF
    always_comb begin
        b_x = ptr_x[sel_ptr];
        b_y = ptr_y[sel_ptr];
        case (bsel_e'(sel_bsel))
            BSEL_SELF: begin
                b_x = ptr_x[sel_ptr];
                b_y = ptr_y[sel_ptr];
            end
            BSEL_SRC: begin
                b_x = ptr_x[sel_src];
                b_y = ptr_y[sel_src];
            end
            BSEL_FRAC: begin
                b_x = frac_x[sel_ptr];
                b_y = frac_y[sel_ptr];
            end
            BSEL_STEP: begin
                b_x = step_x[sel_ptr];
                b_y = step_y[sel_ptr];
            end
            default: begin
                b_x = ptr_x[sel_ptr];
                b_y = ptr_y[sel_ptr];
            end
        endcase
    end

endmodule

// File: rtl/blit_addr_step.sv
// Blitter address-step unit. Holds NPTR pointer channels (pointer, fraction
// and step registers, X and Y each), executes LOAD_* commands in one cycle
// and ADD commands through a SEL -> ADD -> OUT pipeline, presenting the sum
// on a valid/ready output with optional writeback to the pointer.
// Optional build macro BLIT_ADDR_CLIP_EN enables the clip-window flag.
module blit_addr_step
    import blit_addr_pkg::*;
#(
    parameter int W    = 16,
    parameter int NPTR = 2,
    localparam int PTR_W = $clog2(NPTR)
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [PTR_W-1:0] cmd_ptr,
    input  logic [PTR_W-1:0] cmd_src,
    input  logic [1:0]       cmd_bsel,
    input  logic             cmd_wb,
    input  logic [W-1:0]     cmd_x,
    input  logic [W-1:0]     cmd_y,
    input  logic [W-1:0]     clip_w,
    input  logic [W-1:0]     clip_h,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_x,
    output logic [W-1:0]     out_y,
    output logic [PTR_W-1:0] out_ptr,
    output logic             out_cx,
    output logic             out_cy,
    output logic             out_clip
);

    state_e state_q, state_d;

    // Captured ADD command
    logic [PTR_W-1:0] cap_ptr_q, cap_ptr_d;
    logic [PTR_W-1:0] cap_src_q, cap_src_d;
    logic [1:0]       cap_bsel_q, cap_bsel_d;
    logic             cap_wb_q, cap_wb_d;

    // Operands registered in SEL
    logic [W-1:0] a_x_q, a_x_d, a_y_q, a_y_d;
    logic [W-1:0] b_x_q, b_x_d, b_y_q, b_y_d;

    // Result registers
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_x_q, out_x_d, out_y_q, out_y_d;
    logic [PTR_W-1:0] out_ptr_q, out_ptr_d;
    logic             out_cx_q, out_cx_d, out_cy_q, out_cy_d;
    logic             out_clip_q, out_clip_d;

    // Per-channel register banks
    logic [W-1:0] ptr_x_q  [NPTR], ptr_x_d  [NPTR];
    logic [W-1:0] ptr_y_q  [NPTR], ptr_y_d  [NPTR];
    logic [W-1:0] frac_x_q [NPTR], frac_x_d [NPTR];
    logic [W-1:0] frac_y_q [NPTR], frac_y_d [NPTR];
    logic [W-1:0] step_x_q [NPTR], step_x_d [NPTR];
    logic [W-1:0] step_y_q [NPTR], step_y_d [NPTR];

    logic [NPTR*W-1:0] ptr_x_flat, ptr_y_flat;
    logic [NPTR*W-1:0] frac_x_flat, frac_y_flat;
    logic [NPTR*W-1:0] step_x_flat, step_y_flat;

    logic [W-1:0] sel_b_x, sel_b_y;
    logic [W:0]   sum_x, sum_y;
    logic         clip_calc;
    logic         cmd_fire;

    assign cmd_ready = (state_q == ST_IDLE) & ~reset;
    assign cmd_fire  = cmd_valid & cmd_ready;

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_ptr   = out_ptr_q;
    assign out_cx    = out_cx_q;
    assign out_cy    = out_cy_q;
    assign out_clip  = out_clip_q;

    genvar gi;
    generate
        for (gi = 0; gi < NPTR; gi++) begin : g_flat
            assign ptr_x_flat[gi*W +: W]  = ptr_x_q[gi];
            assign ptr_y_flat[gi*W +: W]  = ptr_y_q[gi];
            assign frac_x_flat[gi*W +: W] = frac_x_q[gi];
            assign frac_y_flat[gi*W +: W] = frac_y_q[gi];
            assign step_x_flat[gi*W +: W] = step_x_q[gi];
            assign step_y_flat[gi*W +: W] = step_y_q[gi];
        end
    endgenerate

    blit_addb_sel #(
        .W    (W),
        .NPTR (NPTR)
    ) u_addb_sel (
        .ptr_x_flat  (ptr_x_flat),
        .ptr_y_flat  (ptr_y_flat),
        .frac_x_flat (frac_x_flat),
        .frac_y_flat (frac_y_flat),
        .step_x_flat (step_x_flat),
        .step_y_flat (step_y_flat),
        .sel_ptr     (cap_ptr_q),
        .sel_src     (cap_src_q),
        .sel_bsel    (cap_bsel_q),
        .b_x         (sel_b_x),
        .b_y         (sel_b_y)
    );

    // Full-width adds; the top bit is the carry-out, the sum wraps mod 2^W
    assign sum_x = {1'b0, a_x_q} + {1'b0, b_x_q};
    assign sum_y = {1'b0, a_y_q} + {1'b0, b_y_q};

`ifdef BLIT_ADDR_CLIP_EN
    // Negative coordinates (MSB set) are always outside; otherwise compare unsigned
    assign clip_calc = sum_x[W-1] | sum_y[W-1] |
                       (sum_x[W-1:0] >= clip_w) | (sum_y[W-1:0] >= clip_h);
`else
    logic unused_clip;
    assign unused_clip = ^{clip_w, clip_h};
    assign clip_calc   = 1'b0;
`endif

    // Next-state, command capture, operand select, result and register-bank updates
    always_comb begin
        state_d     = state_q;
        cap_ptr_d   = cap_ptr_q;
        cap_src_d   = cap_src_q;
        cap_bsel_d  = cap_bsel_q;
        cap_wb_d    = cap_wb_q;
        a_x_d       = a_x_q;
        a_y_d       = a_y_q;
        b_x_d       = b_x_q;
        b_y_d       = b_y_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_ptr_d   = out_ptr_q;
        out_cx_d    = out_cx_q;
        out_cy_d    = out_cy_q;
        out_clip_d  = out_clip_q;
        ptr_x_d     = ptr_x_q;
        ptr_y_d     = ptr_y_q;
        frac_x_d    = frac_x_q;
        frac_y_d    = frac_y_q;
        step_x_d    = step_x_q;
        step_y_d    = step_y_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (is_load(cmd_op)) begin
                        case (op_e'(cmd_op))
                            OP_LOAD_PTR: begin
                                ptr_x_d[cmd_ptr] = cmd_x;
                                ptr_y_d[cmd_ptr] = cmd_y;
                            end
                            OP_LOAD_STEP: begin
                                step_x_d[cmd_ptr] = cmd_x;
                                step_y_d[cmd_ptr] = cmd_y;
                            end
                            OP_LOAD_FRAC: begin
                                frac_x_d[cmd_ptr] = cmd_x;
                                frac_y_d[cmd_ptr] = cmd_y;
                            end
                            default: begin
                                ptr_x_d[cmd_ptr] = ptr_x_q[cmd_ptr];
                            end
                        endcase
                    end else begin
                        cap_ptr_d  = cmd_ptr;
                        cap_src_d  = cmd_src;
                        cap_bsel_d = cmd_bsel;
                        cap_wb_d   = cmd_wb;
                        state_d    = ST_SEL;
                    end
                end
            end
            ST_SEL: begin
                a_x_d   = ptr_x_q[cap_ptr_q];
                a_y_d   = ptr_y_q[cap_ptr_q];
                b_x_d   = sel_b_x;
                b_y_d   = sel_b_y;
                state_d = ST_ADD;
            end
            ST_ADD: begin
                out_valid_d = 1'b1;
                out_x_d     = sum_x[W-1:0];
                out_y_d     = sum_y[W-1:0];
                out_ptr_d   = cap_ptr_q;
                out_cx_d    = sum_x[W];
                out_cy_d    = sum_y[W];
                out_clip_d  = clip_calc;
                if (cap_wb_q) begin
                    ptr_x_d[cap_ptr_q] = sum_x[W-1:0];
                    ptr_y_d[cap_ptr_q] = sum_y[W-1:0];
                end
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears banks and outputs, dropping any in-flight ADD
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cap_ptr_q   <= '0;
            cap_src_q   <= '0;
            cap_bsel_q  <= '0;
            cap_wb_q    <= 1'b0;
            a_x_q       <= '0;
            a_y_q       <= '0;
            b_x_q       <= '0;
            b_y_q       <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_ptr_q   <= '0;
            out_cx_q    <= 1'b0;
            out_cy_q    <= 1'b0;
            out_clip_q  <= 1'b0;
            for (int i = 0; i < NPTR; i++) begin
                ptr_x_q[i]  <= '0;
                ptr_y_q[i]  <= '0;
                frac_x_q[i] <= '0;
                frac_y_q[i] <= '0;
                step_x_q[i] <= '0;
                step_y_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cap_ptr_q   <= cap_ptr_d;
            cap_src_q   <= cap_src_d;
            cap_bsel_q  <= cap_bsel_d;
            cap_wb_q    <= cap_wb_d;
            a_x_q       <= a_x_d;
            a_y_q       <= a_y_d;
            b_x_q       <= b_x_d;
            b_y_q       <= b_y_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_ptr_q   <= out_ptr_d;
            out_cx_q    <= out_cx_d;
            out_cy_q    <= out_cy_d;
            out_clip_q  <= out_clip_d;
            ptr_x_q     <= ptr_x_d;
            ptr_y_q     <= ptr_y_d;
            frac_x_q    <= frac_x_d;
            frac_y_q    <= frac_y_d;
            step_x_q    <= step_x_d;
            step_y_q    <= step_y_d;
        end
    end

endmodule
